// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache - direct-mapped instruction cache in front of the instruction fetcher
//
// Looks up the fetcher's PC, answers hits one cycle after the request is
// accepted, and refills missing lines one word at a time from the memory
// controller. A mispredict flush from the ROB drops any pending response but
// lets an in-flight refill run to completion so the memory transaction stays
// consistent.
//
// Optional build macro: ICACHE_CWF_EN
//   defined   - critical-word-first refill: the refill starts at the requested
//               word, wraps around the line, and the response is issued the
//               cycle after that word arrives.
//   undefined - refill always starts at word 0; the response is issued from
//               the RESP state after the whole line has been written.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rdy           global ready; when low every register and the arrays hold
//   IF_pc_sgn     fetch request valid (level)
//   IF_pc         fetch address (bits [1:0] ignored)
//   IF_ins_sgn    one-cycle pulse, IF_ins valid
//   IF_ins        instruction word
//   MC_req        refill word request (level)
//   MC_addr       word-aligned refill address
//   MC_done       one-cycle pulse, MC_data valid for the current MC_addr
//   MC_data       refill word
//   ROB_jp_wrong  mispredict flush
// ----------------------------------------------------------------------------
module icache #(
    parameter int INDEX_BITS       = 6,
    parameter int OFFSET_WORDS_LOG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data,
    input  logic        ROB_jp_wrong
);

    localparam int LINES   = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << OFFSET_WORDS_LOG;
    localparam int TAG_LSB = 2 + OFFSET_WORDS_LOG + INDEX_BITS;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    state_t state;

    // Line storage: valid bits are control state and get reset; tags and
    // data are only meaningful under a set valid bit, so they are not reset.
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];

    logic [TAG_W-1:0]            pc_tag;
    logic [INDEX_BITS-1:0]       pc_idx;
    logic [OFFSET_WORDS_LOG-1:0] pc_word;
    logic [OFFSET_WORDS_LOG-1:0] start_word;
    logic [OFFSET_WORDS_LOG-1:0] mc_word;
    logic [OFFSET_WORDS_LOG-1:0] mc_word_nxt;
    logic unused_pc_bits;

    logic [TAG_W-1:0]            req_tag;
    logic [INDEX_BITS-1:0]       req_idx;
    logic [OFFSET_WORDS_LOG-1:0] req_word;
    logic [OFFSET_WORDS_LOG-1:0] cnt;
    logic                        abandon;

    logic hit;
    logic accept;
    logic fill_we;
    logic last_word;

    assign pc_tag         = IF_pc[31:TAG_LSB];
    assign pc_idx         = IF_pc[TAG_LSB-1:OFFSET_WORDS_LOG+2];
    assign pc_word        = IF_pc[OFFSET_WORDS_LOG+1:2];
    assign unused_pc_bits = ^IF_pc[1:0];

    // The word slot being written is taken from MC_addr itself, so the same
    // path works for both the linear and the wrapping refill order.
    assign mc_word     = MC_addr[OFFSET_WORDS_LOG+1:2];
    assign mc_word_nxt = mc_word + OFFSET_WORDS_LOG'(1);

`ifdef ICACHE_CWF_EN
    assign start_word = pc_word;
`else
    assign start_word = '0;
`endif

    assign hit = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);

    // IF_ins_sgn in the accept term forces a bubble cycle after every
    // response, which gives the fetcher time to present its next PC.
    assign accept = (state == IDLE) && IF_pc_sgn && !IF_ins_sgn && !ROB_jp_wrong;

    assign fill_we   = rdy && !rst && (state == REFILL) && MC_done;
    assign last_word = (cnt == {OFFSET_WORDS_LOG{1'b1}});

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{req_idx, mc_word}] <= MC_data;
            if (last_word) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            IF_ins_sgn <= 1'b0;
            IF_ins     <= '0;
            MC_req     <= 1'b0;
            MC_addr    <= '0;
            cnt        <= '0;
            abandon    <= 1'b0;
        end else if (rdy) begin
            IF_ins_sgn <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_tag  <= pc_tag;
                        req_idx  <= pc_idx;
                        req_word <= pc_word;
                        if (hit) begin
                            IF_ins_sgn <= 1'b1;
                            IF_ins     <= data_mem[{pc_idx, pc_word}];
                        end else begin
                            state   <= REFILL;
                            MC_req  <= 1'b1;
                            MC_addr <= {pc_tag, pc_idx, start_word, 2'b00};
                            cnt     <= '0;
                            abandon <= 1'b0;
                        end
                    end
                end

                REFILL: begin
                    // A flush never stops the refill: the memory controller
                    // is mid-transaction, so the line is finished and kept.
                    if (ROB_jp_wrong) begin
                        abandon <= 1'b1;
                    end
                    if (MC_done) begin
                        cnt     <= cnt + OFFSET_WORDS_LOG'(1);
                        MC_addr <= {MC_addr[31:OFFSET_WORDS_LOG+2], mc_word_nxt, 2'b00};
`ifdef ICACHE_CWF_EN
                        // The first word returned is the requested one.
                        if ((cnt == '0) && !abandon && !ROB_jp_wrong) begin
                            IF_ins_sgn <= 1'b1;
                            IF_ins     <= MC_data;
                        end
`endif
                        if (last_word) begin
                            MC_req         <= 1'b0;
                            valid[req_idx] <= 1'b1;
`ifdef ICACHE_CWF_EN
                            state <= IDLE;
`else
                            state <= (abandon || ROB_jp_wrong) ? IDLE : RESP;
`endif
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                    if (!ROB_jp_wrong) begin
                        IF_ins_sgn <= 1'b1;
                        IF_ins     <= data_mem[{req_idx, req_word}];
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
